gradient_frame_writer: RTL and testbench

GRADIENT_FRAME_WRITER -- requirements
Module: gradient_frame_writer

---
 rtl/gradient_frame_writer.sv | 175 +++++++++++++++++
 tb/tb_gradient_frame_writer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gradient_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : gradient_frame_writer
// Brief    : Captures one frame of Sobel gradients (saturated magnitude plus
//            thresholded edge bit) into a buffer and streams it out on request.
// Revision : 1.0  initial release
// ============================================================================
module gradient_frame_writer #(
  parameter int OUT_COLS   = 62,
  parameter int OUT_ROWS   = 62,
  parameter int GRAD_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [GRAD_WIDTH-1:0]                  gradient,
  input  logic                                   gradient_valid,
  input  logic [GRAD_WIDTH-1:0]                  threshold,
  input  logic                                   rd_start,
  output logic [DATA_WIDTH:0]                    rd_data,
  output logic                                   rd_valid,
  input  logic                                   rd_ready,
  output logic                                   rd_last,
  output logic                                   frame_done,
  output logic [$clog2(OUT_COLS*OUT_ROWS+1)-1:0] edge_count,
  output logic                                   overrun
);

  localparam int c_depth  = OUT_COLS * OUT_ROWS;
  localparam int c_addr_w = (c_depth > 1) ? $clog2(c_depth) : 1;
  localparam int c_cnt_w  = $clog2(c_depth + 1);
  localparam int c_col_w  = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int c_row_w  = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;

  localparam logic [c_addr_w-1:0] c_addr_last = c_addr_w'(c_depth - 1);
  localparam logic [c_addr_w-1:0] c_addr_one  = c_addr_w'(1);
  localparam logic [c_col_w-1:0]  c_col_last  = c_col_w'(OUT_COLS - 1);
  localparam logic [c_col_w-1:0]  c_col_one   = c_col_w'(1);
  localparam logic [c_row_w-1:0]  c_row_last  = c_row_w'(OUT_ROWS - 1);
  localparam logic [c_row_w-1:0]  c_row_one   = c_row_w'(1);

  typedef enum logic [1:0] {
    S_CAPTURE = 2'd0,
    S_DONE    = 2'd1,
    S_READOUT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_WIDTH:0]   r_mem [c_depth];
  logic [c_addr_w-1:0]   r_wr_addr;
  logic [c_col_w-1:0]    r_col;
  logic [c_row_w-1:0]    r_row;
  logic [GRAD_WIDTH-1:0] r_thr;
  logic [c_cnt_w-1:0]    r_edge_cnt;
  logic [c_cnt_w-1:0]    r_edge_count;
  logic                  r_frame_done;
  logic                  r_overrun;
  logic [c_addr_w-1:0]   r_rd_ptr;
  logic [DATA_WIDTH:0]   r_rd_data;
  logic                  r_rd_valid;
  logic                  r_rd_last;

  logic [DATA_WIDTH-1:0] w_mag;
  logic [GRAD_WIDTH-1:0] w_thr;
  logic                  w_edge;
  logic [DATA_WIDTH:0]   w_word;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_wr_last;
  logic [c_cnt_w-1:0]    w_edge_sum;
  logic                  w_load;
  logic [c_addr_w-1:0]   w_rd_addr;

  generate
    if (GRAD_WIDTH > DATA_WIDTH) begin : g_sat
      assign w_mag = (|gradient[GRAD_WIDTH-1:DATA_WIDTH]) ? {DATA_WIDTH{1'b1}}
                                                          : gradient[DATA_WIDTH-1:0];
    end else begin : g_nosat
      assign w_mag = DATA_WIDTH'(gradient);
    end
  endgenerate

  // The first sample of a frame is judged against the live threshold it latches.
  assign w_thr      = (r_wr_addr == '0) ? threshold : r_thr;
  assign w_edge     = (gradient >= w_thr);
  assign w_word     = {w_edge, w_mag};
  assign w_accept   = (r_state == S_CAPTURE) && gradient_valid;
  assign w_drop     = (r_state != S_CAPTURE) && gradient_valid;
  assign w_wr_last  = (r_col == c_col_last) && (r_row == c_row_last);
  assign w_edge_sum = r_edge_cnt + c_cnt_w'(w_edge);

  // Fetch word 0 on the rd_start edge itself, then refill whenever the output slot frees.
  assign w_load    = ((r_state == S_DONE) && rd_start) ||
                     ((r_state == S_READOUT) && !r_rd_last && (!r_rd_valid || rd_ready));
  assign w_rd_addr = (r_state == S_DONE) ? '0 : r_rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_CAPTURE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_CAPTURE: if (w_accept && w_wr_last) w_state_next = S_DONE;
      S_DONE:    if (rd_start) w_state_next = S_READOUT;
      S_READOUT: if (r_rd_valid && rd_ready && r_rd_last) w_state_next = S_CAPTURE;
      default:   w_state_next = S_CAPTURE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_addr] <= w_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_addr    <= '0;
      r_col        <= '0;
      r_row        <= '0;
      r_thr        <= '0;
      r_edge_cnt   <= '0;
      r_edge_count <= '0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_rd_ptr     <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_last    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_accept) begin
        if (r_wr_addr == '0) r_thr <= threshold;
        if (w_wr_last) begin
          r_wr_addr    <= '0;
          r_col        <= '0;
          r_row        <= '0;
          r_edge_cnt   <= '0;
          r_edge_count <= w_edge_sum;
          r_frame_done <= 1'b1;
        end else begin
          r_wr_addr  <= r_wr_addr + c_addr_one;
          r_edge_cnt <= w_edge_sum;
          if (r_col == c_col_last) begin
            r_col <= '0;
            r_row <= r_row + c_row_one;
          end else begin
            r_col <= r_col + c_col_one;
          end
        end
      end
      if (w_drop) r_overrun <= 1'b1;
      if (w_load) begin
        r_rd_data  <= r_mem[w_rd_addr];
        r_rd_valid <= 1'b1;
        r_rd_last  <= (w_rd_addr == c_addr_last);
        r_rd_ptr   <= w_rd_addr + c_addr_one;
      end else if (r_rd_valid && rd_ready) begin
        r_rd_valid <= 1'b0;
        r_rd_last  <= 1'b0;
      end
    end
  end

  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign rd_last    = r_rd_last;
  assign frame_done = r_frame_done;
  assign edge_count = r_edge_count;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_gradient_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gradient_frame_writer
// Brief    : Randomized scoreboard bench for gradient_frame_writer (4x4 frame).
// Revision : 1.0  initial release
// ============================================================================
module tb_gradient_frame_writer;

  localparam int COLS = 4;
  localparam int ROWS = 4;
  localparam int GW   = 11;
  localparam int DW   = 8;
  localparam int N    = COLS * ROWS;

  logic          clk = 1'b0;
  logic          rst;
  logic [GW-1:0] gradient;
  logic          gradient_valid;
  logic [GW-1:0] threshold;
  logic          rd_start;
  logic [DW:0]   rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_last;
  logic          frame_done;
  logic [4:0]    edge_count;
  logic          overrun;

  always #5 clk = ~clk;

  gradient_frame_writer #(
    .OUT_COLS(COLS), .OUT_ROWS(ROWS), .GRAD_WIDTH(GW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .rst(rst), .gradient(gradient), .gradient_valid(gradient_valid),
    .threshold(threshold), .rd_start(rd_start), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
    .frame_done(frame_done), .edge_count(edge_count), .overrun(overrun)
  );

  typedef struct packed {
    logic [DW:0] data;
    logic        last;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      ec_q[$];
  int      total = 0;
  int      bad = 0;
  int      fd_pulses = 0;
  logic [GW-1:0] fg[N];
  logic [GW-1:0] ft[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: a frame is a list of samples; threshold comes from sample 0.
  task automatic model_push();
    int cnt = 0;
    logic [GW-1:0] thr = ft[0];
    for (int i = 0; i < N; i++) begin
      logic e;
      logic [DW-1:0] mag;
      e   = (fg[i] >= thr);
      mag = (fg[i] > 255) ? 8'd255 : fg[i][DW-1:0];
      rd_q.push_back('{data: {e, mag}, last: (i == N - 1)});
      cnt += int'(e);
    end
    ec_q.push_back(cnt);
  endtask

  // Monitor: pops expected words on every handshake and checks stall stability.
  logic [DW:0] held_data;
  logic        held_last;
  bit          stalled = 0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (stalled) begin
        chk("hold_valid", 64'(rd_valid), 64'd1);
        chk("hold_data", 64'(rd_data), 64'(held_data));
        chk("hold_last", 64'(rd_last), 64'(held_last));
      end
      stalled   = rd_valid && !rd_ready;
      held_data = rd_data;
      held_last = rd_last;
      if (rd_valid && rd_ready) begin
        if (rd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rd: actual=%0d required=none", rd_data);
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          chk("rd_data", 64'(rd_data), 64'(e.data));
          chk("rd_last", 64'(rd_last), 64'(e.last));
        end
      end
      if (frame_done) begin
        fd_pulses++;
        if (ec_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame_done: actual=1 required=0");
        end else begin
          chk("edge_count", 64'(edge_count), 64'(ec_q.pop_front()));
        end
      end
    end else begin
      stalled = 0;
    end
  end

  task automatic drive_samples(input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        threshold = GW'($urandom);
        @(posedge clk); #1;
      end
      gradient       = fg[i];
      threshold      = ft[i];
      gradient_valid = 1'b1;
      @(posedge clk); #1;
      gradient_valid = 1'b0;
    end
  endtask

  task automatic capture_frame(input int max_gap);
    model_push();
    drive_samples(N, max_gap);
    @(negedge clk);
    chk("frame_done_timing", 64'(frame_done), 64'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic next_ready(input int mode, input logic cur);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ~cur;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic readout(input int mode);
    int lat = 0;
    int cyc = 0;
    bit seen = 0;
    rd_ready = 1'b1;
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    rd_ready = next_ready(mode, rd_ready);
    while (!seen && lat < 3) begin
      @(negedge clk);
      lat++;
      if (rd_valid) seen = 1;
    end
    chk("rd_latency_le2", 64'(seen && lat <= 2), 64'd1);
    while ((rd_q.size() > 0 || rd_valid) && cyc < 200) begin
      @(posedge clk); #1;
      rd_ready = next_ready(mode, rd_ready);
      cyc++;
    end
    chk("readout_drained", 64'(rd_q.size()), 64'd0);
    rd_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd_base;
    rst = 1'b0; gradient = '0; gradient_valid = 1'b0; threshold = '0;
    rd_start = 1'b0; rd_ready = 1'b1;
    #12;
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_rd_last", 64'(rd_last), 64'd0);
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    chk("reset_frame_done", 64'(frame_done), 64'd0);
    chk("reset_edge_count", 64'(edge_count), 64'd0);
    chk("reset_overrun", 64'(overrun), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Ramp 0..1500 step 100, threshold 100, back-to-back, full-rate read.
    for (int i = 0; i < N; i++) begin fg[i] = GW'(i * 100); ft[i] = GW'(100); end
    capture_frame(0);
    chk("ramp_edge_count", 64'(edge_count), 64'd15);
    readout(0);

    // Threshold boundary 49/50/51; later threshold changes must not matter.
    for (int i = 0; i < N; i++) begin fg[i] = GW'($urandom); ft[i] = GW'($urandom); end
    fg[0] = 49; fg[1] = 50; fg[2] = 51; ft[0] = 50; ft[1] = 2000; ft[2] = 0;
    capture_frame(1);
    readout(1);

    // Samples arriving in DONE are dropped; buffer must read out unchanged.
    chk("overrun_clear", 64'(overrun), 64'd0);
    for (int i = 0; i < N; i++) begin fg[i] = GW'($urandom); ft[i] = GW'($urandom_range(0, 600)); end
    capture_frame(0);
    for (int i = 0; i < 3; i++) begin
      gradient = GW'($urandom); gradient_valid = 1'b1;
      @(posedge clk); #1;
    end
    gradient_valid = 1'b0;
    @(negedge clk);
    chk("overrun_set", 64'(overrun), 64'd1);
    @(posedge clk); #1;
    readout(2);
    for (int i = 0; i < N; i++) begin fg[i] = GW'($urandom_range(0, 400)); ft[i] = GW'($urandom_range(0, 400)); end
    capture_frame(0);
    readout(0);
    chk("overrun_sticky", 64'(overrun), 64'd1);

    // Reset after 7 samples abandons the partial frame.
    for (int i = 0; i < N; i++) begin fg[i] = GW'(1000 + i); ft[i] = GW'(0); end
    drive_samples(7, 0);
    rst = 1'b0;
    #2;
    chk("midreset_overrun", 64'(overrun), 64'd0);
    chk("midreset_edge_count", 64'(edge_count), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    fd_base = fd_pulses;
    for (int i = 0; i < N; i++) begin fg[i] = GW'($urandom_range(0, 300)); ft[i] = GW'($urandom_range(0, 300)); end
    ft[0] = 150;
    capture_frame(0);
    readout(1);
    chk("postreset_frame_done_once", 64'(fd_pulses - fd_base), 64'd1);

    // rd_start during CAPTURE must be ignored.
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rd_start_ignored", 64'(rd_valid), 64'd0);

    // Random frames with gaps and random backpressure.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) begin fg[i] = GW'($urandom); ft[i] = GW'($urandom); end
      capture_frame(2);
      readout(2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
